dac_frame_sequencer: RTL and testbench

- Upstream feeder for the DAC interface stage.
- Buffers stereo frames (left/right 24-bit pairs) from the DSP chain in a small FIFO.
- Serialises each frame into alternating left-then-right 24-bit words on the word_valid/word_ready/data_word handshake that the DAC interface consumes.
- Holds off output until the FIFO is primed, inserts zero frames on underrun, supports soft mute, and counts underruns for debug.

---
 rtl/dac_frame_sequencer.sv | 122 ++++++++++++
 tb/tb_dac_frame_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_sequencer.sv
// Stereo frame FIFO feeding the DAC interface: serialises left/right word pairs,
// waits for priming, and inserts zero frames when the DSP chain falls behind.
module dac_frame_sequencer #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8,
    parameter int PRIME  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    input  logic [DATA_W-1:0]        left_in,
    input  logic [DATA_W-1:0]        right_in,
    input  logic                     mute,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [DATA_W-1:0]        data_word,
    output logic                     word_is_right,
    output logic [$clog2(DEPTH):0]   fill_count,
    output logic [CNT_W-1:0]         underrun_count,
    input  logic                     underrun_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_C = (AW+1)'(PRIME);

    typedef enum logic [1:0] {S_PRIME, S_LEFT, S_RIGHT} state_t;

    state_t            state;
    logic              fill_flag;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem_l [DEPTH];
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic empty;
    logic push;
    logic pop;
    logic underrun_inc;

    assign empty        = (fill_count == '0);
    assign frame_ready  = (fill_count != DEPTH_C);
    assign push         = frame_valid & frame_ready;
    assign pop          = (state == S_RIGHT) & word_ready & ~fill_flag;
    assign underrun_inc = (state == S_LEFT) & word_ready & empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr] <= left_in;
            mem_r[wr_ptr] <= right_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fill_count <= fill_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // The fill decision is frozen at the left handshake so a frame arriving
    // during a fill right word can never be split across a pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_PRIME;
            word_valid     <= 1'b0;
            word_is_right  <= 1'b0;
            fill_flag      <= 1'b0;
            underrun_count <= '0;
        end else begin
            case (state)
                S_PRIME: begin
                    if (fill_count >= PRIME_C) begin
                        state      <= S_LEFT;
                        word_valid <= 1'b1;
                    end
                end
                S_LEFT: begin
                    if (word_ready) begin
                        state         <= S_RIGHT;
                        word_is_right <= 1'b1;
                        fill_flag     <= empty;
                    end
                end
                S_RIGHT: begin
                    if (word_ready) begin
                        state         <= S_LEFT;
                        word_is_right <= 1'b0;
                        fill_flag     <= 1'b0;
                    end
                end
                default: state <= S_PRIME;
            endcase

            if (underrun_clr)
                underrun_count <= '0;
            else if (underrun_inc && !(&underrun_count))
                underrun_count <= underrun_count + CNT_W'(1);
        end
    end

    always_comb begin
        data_word = '0;
        if (!mute) begin
            case (state)
                S_LEFT:  if (!empty) data_word = mem_l[rd_ptr];
                S_RIGHT: if (!fill_flag) data_word = mem_r[rd_ptr];
                default: data_word = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Directed self-checking bench for dac_frame_sequencer; a second small instance
// (CNT_W=2) exercises underrun counter saturation within a short run.
module tb_dac_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_valid;
    logic        frame_ready;
    logic [23:0] left_in;
    logic [23:0] right_in;
    logic        mute;
    logic        word_valid;
    logic        word_ready;
    logic [23:0] data_word;
    logic        word_is_right;
    logic [3:0]  fill_count;
    logic [15:0] underrun_count;
    logic        underrun_clr;

    logic        s_frame_valid;
    logic        s_frame_ready;
    logic [23:0] s_left_in;
    logic [23:0] s_right_in;
    logic        s_word_valid;
    logic        s_word_ready;
    logic [23:0] s_data_word;
    logic        s_word_is_right;
    logic [1:0]  s_fill_count;
    logic [1:0]  s_underrun_count;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dac_frame_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .left_in        (left_in),
        .right_in       (right_in),
        .mute           (mute),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .data_word      (data_word),
        .word_is_right  (word_is_right),
        .fill_count     (fill_count),
        .underrun_count (underrun_count),
        .underrun_clr   (underrun_clr)
    );

    dac_frame_sequencer #(.DATA_W(24), .DEPTH(2), .PRIME(1), .CNT_W(2)) sat_dut (
        .clk            (clk),
        .rst            (rst),
        .frame_valid    (s_frame_valid),
        .frame_ready    (s_frame_ready),
        .left_in        (s_left_in),
        .right_in       (s_right_in),
        .mute           (1'b0),
        .word_valid     (s_word_valid),
        .word_ready     (s_word_ready),
        .data_word      (s_data_word),
        .word_is_right  (s_word_is_right),
        .fill_count     (s_fill_count),
        .underrun_count (s_underrun_count),
        .underrun_clr   (1'b0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
        frame_valid = 1'b1;
        left_in     = l;
        right_in    = r;
        tick();
        frame_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] pat;
        int k;
        pat = 32'b1011_0010_0111_0100_1101_0011_1001_0110;

        rst = 1'b0; frame_valid = 1'b0; left_in = '0; right_in = '0;
        mute = 1'b0; word_ready = 1'b0; underrun_clr = 1'b0;
        s_frame_valid = 1'b0; s_left_in = '0; s_right_in = '0; s_word_ready = 1'b0;
        tick();
        tick();
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_frame_ready", 32'(frame_ready), 32'd1);
        check("rst_data_word", 32'(data_word), 32'd0);
        check("rst_word_is_right", 32'(word_is_right), 32'd0);
        check("rst_fill_count", 32'(fill_count), 32'd0);
        check("rst_underrun", 32'(underrun_count), 32'd0);
        rst = 1'b1;

        // Priming: three frames are not enough, the fourth starts streaming a cycle later.
        for (int i = 1; i <= 3; i++) begin
            push_frame(24'(i), 24'h100000 + 24'(i));
            check("prime_hold_valid", 32'(word_valid), 32'd0);
        end
        tick();
        check("prime_fill3", 32'(fill_count), 32'd3);
        check("prime_still_idle", 32'(word_valid), 32'd0);
        push_frame(24'd4, 24'h100004);
        check("prime_fill4", 32'(fill_count), 32'd4);
        check("prime_valid_lag", 32'(word_valid), 32'd0);
        tick();
        check("prime_valid", 32'(word_valid), 32'd1);
        check("prime_first_word", 32'(data_word), 32'h000001);
        check("prime_first_left", 32'(word_is_right), 32'd0);

        // Ordering under a fixed backpressure pattern.
        k = 0;
        for (int c = 0; c < 32 && k < 8; c++) begin
            word_ready = pat[c];
            check("order_word", 32'(data_word),
                  (k % 2 == 0) ? 32'(k / 2 + 1) : 32'h100000 + 32'(k / 2 + 1));
            check("order_side", 32'(word_is_right), 32'(k % 2));
            check("order_fill", 32'(fill_count), 32'(4 - k / 2));
            tick();
            if (pat[c]) k++;
        end
        word_ready = 1'b0;
        check("order_drained", 32'(fill_count), 32'd0);
        check("order_fill_word", 32'(data_word), 32'd0);

        // Full FIFO: a pop in the same cycle does not let a new frame in.
        for (int i = 0; i < 8; i++)
            push_frame(24'h10 + 24'(i), 24'h20 + 24'(i));
        check("full_count", 32'(fill_count), 32'd8);
        check("full_not_ready", 32'(frame_ready), 32'd0);
        check("full_head", 32'(data_word), 32'h10);
        word_ready = 1'b1;
        tick();
        frame_valid = 1'b1; left_in = 24'h99; right_in = 24'h98;
        tick();
        frame_valid = 1'b0; word_ready = 1'b0;
        check("full_no_accept", 32'(fill_count), 32'd7);
        check("full_ready_again", 32'(frame_ready), 32'd1);
        check("full_next_head", 32'(data_word), 32'h11);

        // Drain to empty, then observe an inserted zero frame.
        word_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            check("drain_word", 32'(data_word),
                  (i % 2 == 0) ? 32'h10 + 32'(i / 2 + 1) : 32'h20 + 32'(i / 2 + 1));
            tick();
        end
        check("under_empty", 32'(fill_count), 32'd0);
        check("under_fill_left", 32'(data_word), 32'd0);
        check("under_left_side", 32'(word_is_right), 32'd0);
        check("under_cnt0", 32'(underrun_count), 32'd0);
        tick();
        check("under_fill_right", 32'(data_word), 32'd0);
        check("under_right_side", 32'(word_is_right), 32'd1);
        check("under_cnt1", 32'(underrun_count), 32'd1);
        word_ready = 1'b0;
        push_frame(24'hABCDEF, 24'h123456);
        check("under_late_not_used", 32'(data_word), 32'd0);
        check("under_late_stored", 32'(fill_count), 32'd1);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("under_late_left", 32'(data_word), 32'hABCDEF);
        check("under_late_side", 32'(word_is_right), 32'd0);
        check("under_late_fill", 32'(fill_count), 32'd1);
        check("under_cnt_hold", 32'(underrun_count), 32'd1);

        // Mute blanks words immediately but frames are still consumed.
        push_frame(24'h55, 24'h66);
        check("mute_fill2", 32'(fill_count), 32'd2);
        mute = 1'b1;
        #1;
        check("mute_immediate", 32'(data_word), 32'd0);
        word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("mute_word", 32'(data_word), 32'd0);
            check("mute_side", 32'(word_is_right), 32'(i % 2));
            tick();
        end
        word_ready = 1'b0;
        mute = 1'b0;
        check("mute_consumed", 32'(fill_count), 32'd0);
        check("mute_no_underrun", 32'(underrun_count), 32'd1);

        // Clear coinciding with an underrun increment wins.
        word_ready = 1'b1;
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        word_ready = 1'b0;
        check("clr_wins", 32'(underrun_count), 32'd0);
        check("clr_fill_right", 32'(word_is_right), 32'd1);

        // Async reset while a right word is stalled with five frames buffered.
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_frame(24'h30 + 24'(i), 24'h40 + 24'(i));
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("pre_rst_side", 32'(word_is_right), 32'd1);
        check("pre_rst_fill", 32'(fill_count), 32'd5);
        check("pre_rst_word", 32'(data_word), 32'h40);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(word_valid), 32'd0);
        check("arst_fill", 32'(fill_count), 32'd0);
        check("arst_ready", 32'(frame_ready), 32'd1);
        check("arst_word", 32'(data_word), 32'd0);
        check("arst_side", 32'(word_is_right), 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            push_frame(24'h70 + 24'(i), 24'h80 + 24'(i));
        tick();
        check("reprime_fill", 32'(fill_count), 32'd3);
        check("reprime_idle", 32'(word_valid), 32'd0);

        // Saturation on the narrow-counter instance.
        s_frame_valid = 1'b1; s_left_in = 24'h7; s_right_in = 24'h8;
        tick();
        s_frame_valid = 1'b0;
        tick();
        check("sat_primed", 32'(s_word_valid), 32'd1);
        check("sat_first", 32'(s_data_word), 32'h7);
        s_word_ready = 1'b1;
        tick();
        check("sat_right", 32'(s_data_word), 32'h8);
        tick();
        tick();
        check("sat_cnt1", 32'(s_underrun_count), 32'd1);
        repeat (4) tick();
        check("sat_cnt3", 32'(s_underrun_count), 32'd3);
        repeat (10) tick();
        check("sat_hold", 32'(s_underrun_count), 32'd3);
        s_word_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
